display_feeder: RTL and testbench

Queues values written by the processor-side bus and hands them to the seven-segment display stage one at a time. Each value is issued as a single-cycle `SEG_we` pulse with `SEG_wdata`. The next value is held back until the display stage reports the end of its viewing window on `PulsoFin`, so back-to-back software writes are never overwritten mid-display. Sits directly upstream of the display stage, between the bus write decode and its `SEG_we`/`SEG_wdata`/`PulsoFin` ports.

---
 rtl/display_feeder_if.sv | 39 +++
 rtl/display_feeder.sv | 114 +++++++++++
 tb/tb_display_feeder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/display_feeder_if.sv
// display_feeder_if
// Bundles the processor-side push bus, the display-stage handshake and the
// queue status of display_feeder.
//   master : the side that writes values and sees SEG_* (bus decode + display)
//   slave  : display_feeder itself
// Signals:
//   wr_en, wr_data, flush, clr_ovf : push / maintenance requests
//   PulsoFin                       : end-of-window pulse from the display stage
//   SEG_we, SEG_wdata              : issue strobe and value to the display stage
//   busy, full, empty, count, overflow : queue and issue status
interface display_feeder_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              clr_ovf;
  logic              PulsoFin;
  logic              SEG_we;
  logic [31:0]       SEG_wdata;
  logic              busy;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, flush, clr_ovf, PulsoFin,
    input  SEG_we, SEG_wdata, busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, PulsoFin,
    output SEG_we, SEG_wdata, busy, full, empty, count, overflow
  );
endinterface

// File: rtl/display_feeder.sv
// display_feeder
// Queues values written by the processor bus and hands them one at a time to
// the seven-segment display stage. A value is issued as a one-cycle SEG_we
// pulse; the next one is held back until the display stage returns PulsoFin.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : display_feeder_if slave modport (push bus, display handshake, status)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing outstanding; pops the head as soon as the queue holds one
// WAIT  | a value was issued; waiting for PulsoFin from the display stage
module display_feeder #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                reset,
  display_feeder_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              seg_we;
  logic [31:0]       seg_wdata;

  logic full_w;
  logic empty_w;
  logic pop;
  logic push;
  logic drop;

  assign full_w  = (count == CW'(DEPTH));
  assign empty_w = (count == '0);

  // Pop decision uses the registered count, so a push into an empty queue
  // can never be popped on the same edge. Flush cancels everything.
  assign pop  = (state == IDLE) && !empty_w && !bus.flush;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push = bus.wr_en && (!full_w || pop) && !bus.flush;
  assign drop = bus.wr_en && full_w && !pop && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      seg_we    <= 1'b0;
      seg_wdata <= '0;
      state     <= IDLE;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // Setting wins over clearing when both land on the same edge.
      if (drop)             overflow <= 1'b1;
      else if (bus.clr_ovf) overflow <= 1'b0;

      case (state)
        IDLE: begin
          seg_we <= 1'b0;
          if (pop) begin
            seg_we    <= 1'b1;
            seg_wdata <= 32'(mem[rd_ptr]);
            state     <= WAIT;
          end
        end
        WAIT: begin
          seg_we <= 1'b0;
          if (bus.PulsoFin) state <= IDLE;
        end
        default: begin
          seg_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.SEG_we    = seg_we;
  assign bus.SEG_wdata = seg_wdata;
  assign bus.busy      = (state == WAIT);
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_display_feeder.sv
// tb_display_feeder
// Directed-vector bench for display_feeder (DEPTH=8, DATA_W=8). Inputs change
// 1 ns after a rising edge; outputs are checked at that same point.
module tb_display_feeder;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  display_feeder_if #(.DEPTH(8), .DATA_W(8)) dif ();

  display_feeder #(.DEPTH(8), .DATA_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulso();
    dif.PulsoFin = 1'b1;
    tick();
    dif.PulsoFin = 1'b0;
  endtask

  logic [7:0] exp_q [9];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset        = 1'b0;
    dif.wr_en    = 1'b0;
    dif.wr_data  = '0;
    dif.flush    = 1'b0;
    dif.clr_ovf  = 1'b0;
    dif.PulsoFin = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_we",    32'(dif.SEG_we),   0);
    chk("rst_wdata", dif.SEG_wdata,     0);
    chk("rst_busy",  32'(dif.busy),     0);
    chk("rst_full",  32'(dif.full),     0);
    chk("rst_empty", 32'(dif.empty),    1);
    chk("rst_count", 32'(dif.count),    0);
    chk("rst_ovf",   32'(dif.overflow), 0);
    reset = 1'b1;
    tick();

    // Single push: issue latency
    dif.wr_en = 1'b1; dif.wr_data = 8'h3C;
    tick();                                   // E0
    dif.wr_en = 1'b0;
    chk("e0_count", 32'(dif.count),  1);
    chk("e0_empty", 32'(dif.empty),  0);
    chk("e0_we",    32'(dif.SEG_we), 0);
    tick();                                   // E1
    chk("e1_we",    32'(dif.SEG_we), 1);
    chk("e1_wdata", dif.SEG_wdata,   32'h3C);
    chk("e1_busy",  32'(dif.busy),   1);
    chk("e1_count", 32'(dif.count),  0);
    tick();                                   // E2
    chk("e2_we",    32'(dif.SEG_we), 0);
    chk("e2_busy",  32'(dif.busy),   1);
    pulso();
    chk("pf_busy",  32'(dif.busy),   0);
    tick();
    chk("idle_we",  32'(dif.SEG_we), 0);

    // Back-to-back pushes
    dif.wr_en = 1'b1; dif.wr_data = 8'h11; tick();
    chk("b2b_c1", 32'(dif.count), 1);
    dif.wr_data = 8'h22; tick();
    chk("b2b_we1",  32'(dif.SEG_we), 1);
    chk("b2b_wd1",  dif.SEG_wdata,   32'h11);
    chk("b2b_c2",   32'(dif.count),  1);
    dif.wr_data = 8'h33; tick();
    dif.wr_en = 1'b0;
    chk("b2b_c3",   32'(dif.count),  2);
    chk("b2b_we0",  32'(dif.SEG_we), 0);
    tick(); tick();
    chk("b2b_hold", 32'(dif.SEG_we), 0);
    chk("b2b_hwd",  dif.SEG_wdata,   32'h11);
    pulso();                                  // F
    chk("b2b_fwe",  32'(dif.SEG_we), 0);
    tick();                                   // F+1
    chk("b2b_we2",  32'(dif.SEG_we), 1);
    chk("b2b_wd2",  dif.SEG_wdata,   32'h22);
    tick();
    chk("b2b_strb", 32'(dif.SEG_we), 0);
    pulso();
    tick();
    chk("b2b_we3",  32'(dif.SEG_we), 1);
    chk("b2b_wd3",  dif.SEG_wdata,   32'h33);
    chk("b2b_cend", 32'(dif.count),  0);
    pulso();
    tick();

    // Overflow while held in WAIT
    dif.wr_en = 1'b1; dif.wr_data = 8'hA0; tick();
    dif.wr_en = 1'b0; tick();
    chk("ov_busy", 32'(dif.busy), 1);
    for (int i = 0; i < 8; i++) begin
      dif.wr_en = 1'b1; dif.wr_data = 8'hB0 + 8'(i); tick();
      exp_q[i] = 8'hB0 + 8'(i);
    end
    chk("ov_full8", 32'(dif.full),     1);
    chk("ov_cnt8",  32'(dif.count),    8);
    chk("ov_ovf0",  32'(dif.overflow), 0);
    dif.wr_data = 8'hB8; tick();
    dif.wr_en = 1'b0;
    chk("ov_cnt9",  32'(dif.count),    8);
    chk("ov_ovf1",  32'(dif.overflow), 1);
    dif.clr_ovf = 1'b1; tick(); dif.clr_ovf = 1'b0;
    chk("ov_clr",   32'(dif.overflow), 0);

    // Full with same-edge pop: push accepted, pointers wrap
    pulso();
    chk("fp_busy", 32'(dif.busy),  0);
    chk("fp_cnt",  32'(dif.count), 8);
    dif.wr_en = 1'b1; dif.wr_data = 8'hC0; tick();
    dif.wr_en = 1'b0;
    exp_q[8] = 8'hC0;
    chk("fp_cnt8", 32'(dif.count),    8);
    chk("fp_ovf",  32'(dif.overflow), 0);
    chk("fp_we",   32'(dif.SEG_we),   1);
    chk("fp_wd0",  dif.SEG_wdata,     32'(exp_q[0]));
    for (int i = 1; i < 9; i++) begin
      pulso();
      tick();
      chk("fp_we_i", 32'(dif.SEG_we), 1);
      chk("fp_wd_i", dif.SEG_wdata,   32'(exp_q[i]));
    end
    chk("fp_cend", 32'(dif.count), 0);

    // Flush during WAIT with a simultaneous push
    dif.wr_en = 1'b1; dif.wr_data = 8'hD1; tick();
    dif.wr_data = 8'hD2; tick();
    chk("fl_pre", 32'(dif.count), 2);
    dif.wr_data = 8'hEE; dif.flush = 1'b1; tick();
    dif.wr_en = 1'b0; dif.flush = 1'b0;
    chk("fl_cnt",   32'(dif.count),    0);
    chk("fl_empty", 32'(dif.empty),    1);
    chk("fl_ovf",   32'(dif.overflow), 0);
    chk("fl_busy",  32'(dif.busy),     1);
    tick();
    chk("fl_busy2", 32'(dif.busy),     1);
    pulso();
    chk("fl_idle",  32'(dif.busy),     0);
    tick(); tick();
    chk("fl_nowe",  32'(dif.SEG_we),   0);
    chk("fl_wd",    dif.SEG_wdata,     32'hC0);

    // Async reset mid-WAIT
    dif.wr_en = 1'b1; dif.wr_data = 8'h5A; tick();
    dif.wr_data = 8'h5B; tick();
    dif.wr_en = 1'b0;
    chk("ar_busy", 32'(dif.busy),   1);
    chk("ar_wd",   dif.SEG_wdata,   32'h5A);
    chk("ar_cnt",  32'(dif.count),  1);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy0", 32'(dif.busy),   0);
    chk("ar_we0",   32'(dif.SEG_we), 0);
    chk("ar_wd0",   dif.SEG_wdata,   0);
    chk("ar_cnt0",  32'(dif.count),  0);
    chk("ar_emp",   32'(dif.empty),  1);
    #1 reset = 1'b1;
    tick();
    pulso();
    chk("ar_pf_we", 32'(dif.SEG_we), 0);
    tick();
    chk("ar_pf_we2", 32'(dif.SEG_we), 0);
    chk("ar_pf_bsy", 32'(dif.busy),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
